gdma_wdata_engine: RTL
======================

GDMA_WDATA_ENGINE -- requirements
Module: gdma_wdata_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning write-data width in bits (32, 64 or 128); BYTES = DATA_W/8.
REQ-002 SHALL have parameter ADDR_W, default 49, meaning byte-address width.
REQ-003 SHALL have parameter MAX_BURST, default 256, meaning maximum beats per burst (power of two, 2..256).
REQ-004 SHALL have parameter HDR_DROP, default 2, meaning number of leading stream beats discarded per operation (0..7).
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-007 SHALL have ports start_addr (input, ADDR_W, byte address, low log2(BYTES) bits ignored), length (input, 32, transfer size in bytes), op_start (input, 1, one-cycle start pulse), gdma_addr_done (input, 1, address side finished).
REQ-008 SHALL have ports gdma_done (output, 1, operation complete) and err_resp (output, 1, sticky error: any bresp != OKAY).
REQ-009 SHALL have AXI W/B ports: gdma_ddr_wdata (out, DATA_W), gdma_ddr_wstrb (out, BYTES), gdma_ddr_wlast, gdma_ddr_wvalid (out, 1), gdma_ddr_wready (in, 1), gdma_ddr_bresp (in, 2), gdma_ddr_bvalid (in, 1), gdma_ddr_bready (out, 1).
REQ-010 SHALL have AXI-Stream source ports gtp2gdma_tvalid (in, 1), gtp2gdma_tready (out, 1), gtp2gdma_tdata (in, DATA_W).

Function
REQ-011 SHALL implement states IDLE, DROP, DATA, WAIT_B.
REQ-012 IDLE: on op_start, latch the word address, compute beats = ceil(length/BYTES), clear all counters and err_resp, deassert gdma_done, and go to DROP (HDR_DROP>0), else DATA; op_start outside IDLE SHALL be ignored.
REQ-013 length==0 SHALL skip DROP/DATA and go directly to WAIT_B with zero bursts expected.
REQ-014 DROP: tready=1, wvalid=0; each tvalid&&tready beat increments the drop counter; after HDR_DROP beats go to DATA.
REQ-015 DATA: wvalid=tvalid, tready=wready, wdata=tdata combinationally; IDLE/WAIT_B: tready=0, wvalid=0.
REQ-016 Per accepted beat (wvalid&&wready): address +1 word, beat count +1, burst count +1 (cleared when wlast is accepted).
REQ-017 wlast SHALL assert with wvalid when any holds: current beat is last in its 4 KB page, burst count == MAX_BURST-1, or final beat.
REQ-018 wstrb SHALL be all-ones except on the final beat, where it is the low (length mod BYTES) bits set, all-ones when remainder is 0.
REQ-019 Every accepted wlast SHALL increment the expected-response counter; after the final beat go to WAIT_B.
REQ-020 bready SHALL be constant 1; every bvalid increments the received-response counter; bresp != 2'b00 sets err_resp.
REQ-021 WAIT_B: when gdma_addr_done && received == expected, assert gdma_done next cycle and return to IDLE.
REQ-022 Response counters SHALL be 24 bits wide; simultaneous wlast-accept and bvalid SHALL both count.
REQ-023 Stalls (wready low, tvalid gaps) SHALL hold wdata/wstrb/wlast stable per AXI rules.

Reset
REQ-024 rst_n low at a clock edge SHALL force IDLE, gdma_done=1, err_resp=0, all counters 0; wvalid=0, tready=0 from that edge, including mid-transfer.

Structure
REQ-025 Package gdma_pkg SHALL hold the state enum, the 4 KB page constant and the final-strobe mask function.
REQ-026 Burst-boundary/wlast logic SHALL be one sub-module, gdma_burst_splitter.

Verification (DATA_W=64, MAX_BURST=256, HDR_DROP=2)
REQ-027 start_addr 0x1000, length 64 -> 2 beats dropped, 8 beats with wstrb 0xFF, wlast only on beat 8; one B; gdma_done after B and gdma_addr_done.
REQ-028 start_addr 0x0FF0, length 32 -> 4 beats, wlast on beats 2 and 4; gdma_done only after 2 B responses.
REQ-029 start_addr 0x0, length 2052 -> 257 beats, wlast on beats 256 and 257, final wstrb 0x0F.
REQ-030 bresp 2'b10 on one of two B responses -> err_resp=1 held through gdma_done, cleared by next op_start.
REQ-031 Random wready/tvalid gaps plus rst_n low at beat 3 -> no data change while stalled; IDLE, gdma_done=1 at next edge.
REQ-032 length 0 with gdma_addr_done=1 -> no W beats, tready stays 0, gdma_done returns within 2 cycles.

Source files
------------

// File: rtl/gdma_pkg.sv
// Shared types, constants and helpers for the GDMA write-data engine.
package gdma_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DROP   = 2'd1,
    DATA   = 2'd2,
    WAIT_B = 2'd3
  } state_t;

  localparam int unsigned PAGE_BYTES = 4096;
  localparam int unsigned RESP_W     = 24;

  // Strobe for the final beat: only the trailing bytes of the transfer are valid.
  function automatic logic [15:0] final_strb_mask(input logic [31:0] length,
                                                  input int unsigned bytes);
    logic [31:0] rem;
    logic [31:0] mask;
    rem = length & (bytes - 32'd1);
    if (rem == 32'd0) mask = (32'd1 << bytes) - 32'd1;
    else              mask = (32'd1 << rem) - 32'd1;
    return mask[15:0];
  endfunction

endpackage

// File: rtl/gdma_burst_splitter.sv
// Decides where a write burst ends: 4 KB page edge, burst-length cap or final beat.
module gdma_burst_splitter
  import gdma_pkg::*;
#(
  parameter int BYTES     = 8,
  parameter int MAX_BURST = 256,
  localparam int OFF_W    = $clog2(BYTES),
  localparam int PAGE_W   = $clog2(PAGE_BYTES) - OFF_W,
  localparam int BURST_W  = $clog2(MAX_BURST)
) (
  input  logic [PAGE_W-1:0]  page_word,
  input  logic [BURST_W-1:0] burst_cnt,
  input  logic [31:0]        beat_cnt,
  input  logic [31:0]        beats,
  output logic               final_beat,
  output logic               wlast
);

  assign final_beat = (beat_cnt == beats - 32'd1);
  assign wlast      = final_beat
                    | (&page_word)
                    | (burst_cnt == BURST_W'(MAX_BURST - 1));

endmodule

// File: rtl/gdma_wdata_engine.sv
// GDMA write-data engine: strips stream headers, emits AXI W beats, tracks B responses.
module gdma_wdata_engine
  import gdma_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 49,
  parameter int MAX_BURST = 256,
  parameter int HDR_DROP  = 2,
  localparam int BYTES    = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [31:0]       length,
  input  logic              op_start,
  input  logic              gdma_addr_done,
  output logic              gdma_done,
  output logic              err_resp,
  output logic [DATA_W-1:0] gdma_ddr_wdata,
  output logic [BYTES-1:0]  gdma_ddr_wstrb,
  output logic              gdma_ddr_wlast,
  output logic              gdma_ddr_wvalid,
  input  logic              gdma_ddr_wready,
  input  logic [1:0]        gdma_ddr_bresp,
  input  logic              gdma_ddr_bvalid,
  output logic              gdma_ddr_bready,
  input  logic              gtp2gdma_tvalid,
  output logic              gtp2gdma_tready,
  input  logic [DATA_W-1:0] gtp2gdma_tdata
);

  localparam int OFF_W   = $clog2(BYTES);
  localparam int PAGE_W  = $clog2(PAGE_BYTES) - OFF_W;
  localparam int BURST_W = $clog2(MAX_BURST);

  state_t             state, state_nx;
  logic [PAGE_W-1:0]  page_word;
  logic [31:0]        beats, beat_cnt;
  logic [BURST_W-1:0] burst_cnt;
  logic [2:0]         drop_cnt;
  logic [RESP_W-1:0]  resp_exp, resp_rcv;
  logic [BYTES-1:0]   last_strb;
  logic [32:0]        len_round;
  logic               w_hs, drop_hs, final_beat, split_last, start_op, b_done;

  assign len_round = {1'b0, length} + 33'(BYTES - 1);
  assign start_op  = (state == IDLE) & op_start;
  // Handshakes derived from inputs only, so the output process stays loop-free.
  assign w_hs      = (state == DATA) & gtp2gdma_tvalid & gdma_ddr_wready;
  assign drop_hs   = (state == DROP) & gtp2gdma_tvalid;
  assign b_done    = (state == WAIT_B) & gdma_addr_done & (resp_rcv == resp_exp);

  assign gdma_ddr_wdata  = gtp2gdma_tdata;
  assign gdma_ddr_bready = 1'b1;

  gdma_burst_splitter #(
    .BYTES     (BYTES),
    .MAX_BURST (MAX_BURST)
  ) u_splitter (
    .page_word  (page_word),
    .burst_cnt  (burst_cnt),
    .beat_cnt   (beat_cnt),
    .beats      (beats),
    .final_beat (final_beat),
    .wlast      (split_last)
  );

  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    state_nx        = state;
    gdma_ddr_wvalid = 1'b0;
    gtp2gdma_tready = 1'b0;
    gdma_ddr_wlast  = 1'b0;
    gdma_ddr_wstrb  = final_beat ? last_strb : '1;
    case (state)
      IDLE: begin
        if (op_start) begin
          if (length == 32'd0)   state_nx = WAIT_B;
          else if (HDR_DROP > 0) state_nx = DROP;
          else                   state_nx = DATA;
        end
      end
      DROP: begin
        gtp2gdma_tready = 1'b1;
        if (drop_hs && drop_cnt == 3'(HDR_DROP - 1)) state_nx = DATA;
      end
      DATA: begin
        gdma_ddr_wvalid = gtp2gdma_tvalid;
        gtp2gdma_tready = gdma_ddr_wready;
        gdma_ddr_wlast  = split_last;
        if (w_hs && final_beat) state_nx = WAIT_B;
      end
      WAIT_B: begin
        if (b_done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      gdma_done <= 1'b1;
      err_resp  <= 1'b0;
      page_word <= '0;
      beats     <= '0;
      beat_cnt  <= '0;
      burst_cnt <= '0;
      drop_cnt  <= '0;
      resp_exp  <= '0;
      resp_rcv  <= '0;
      last_strb <= '0;
    end else begin
      state <= state_nx;
      if (start_op) begin
        page_word <= start_addr[$clog2(PAGE_BYTES)-1:OFF_W];
        beats     <= 32'(len_round >> OFF_W);
        last_strb <= BYTES'(final_strb_mask(length, BYTES));
        beat_cnt  <= '0;
        burst_cnt <= '0;
        drop_cnt  <= '0;
        resp_exp  <= '0;
        resp_rcv  <= '0;
        err_resp  <= 1'b0;
        gdma_done <= 1'b0;
      end else begin
        if (drop_hs) drop_cnt <= drop_cnt + 3'd1;
        if (w_hs) begin
          page_word <= page_word + PAGE_W'(1);
          beat_cnt  <= beat_cnt + 32'd1;
          burst_cnt <= split_last ? '0 : burst_cnt + BURST_W'(1);
        end
        // A wlast accept and a B response in the same cycle both count.
        if (w_hs && split_last) resp_exp <= resp_exp + RESP_W'(1);
        if (gdma_ddr_bvalid) begin
          resp_rcv <= resp_rcv + RESP_W'(1);
          if (gdma_ddr_bresp != 2'b00) err_resp <= 1'b1;
        end
        if (b_done) gdma_done <= 1'b1;
      end
    end
  end

endmodule
